// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, funct codes, FSM states, ALU ops and immediate decode for the multicycle core
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_e;

    // Encoded as {funct7[5], funct3} so R/I decode is a direct concatenation
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    function automatic logic [31:0] imm32(input logic [31:0] ir);
        logic [6:0] op;
        op = ir[6:0];
        return op == OP_STORE  ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
               op == OP_BRANCH ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
               op == OP_LUI    ? {ir[31:12], 12'b0} :
               op == OP_JAL    ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                                 {{20{ir[31]}}, ir[31:20]};
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational ALU with branch comparison flags
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] sh;

    assign sh  = b[SW-1:0];
    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    // Result select for the arithmetic, logic, shift and compare ops
    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $signed(a) >>> sh;
            ALU_SLT:  y = XLEN'(lt);
            ALU_SLTU: y = XLEN'(ltu);
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: multicycle RV32I-subset CPU sharing one req/ready memory port for fetch and data
module riscv_multicycle_core
    import riscv_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                NREGS    = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              trap,
    output logic [ADDR_W-1:0] trap_pc
);

    localparam int RW = $clog2(NREGS);

    state_e state, state_n;

    logic [ADDR_W-1:0] pc, pc_old, target;
    logic [31:0]       ir;
    logic [XLEN-1:0]   rs1_q, rs2_q, imm, alu_out, mdr;
    logic [XLEN-1:0]   regs [NREGS];
    logic [XLEN-1:0]   alu_a, alu_b, alu_y;
    alu_op_e           alu_op;
    logic              eq, lt, ltu, taken, redirect, misaligned, legal;

    logic [6:0]    opcode, f7;
    logic [2:0]    f3;
    logic [RW-1:0] rd, rs1, rs2;
    logic          is_r, is_i, is_load, is_store, is_branch, is_lui, is_jal, is_jalr, is_system;

    assign opcode    = ir[6:0];
    assign f3        = ir[14:12];
    assign f7        = ir[31:25];
    assign rd        = ir[7 +: RW];
    assign rs1       = ir[15 +: RW];
    assign rs2       = ir[20 +: RW];
    assign is_r      = opcode == OP_R;
    assign is_i      = opcode == OP_I;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_lui    = opcode == OP_LUI;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_system = opcode == OP_SYSTEM;

    // Legality of the latched instruction; anything not listed traps
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:              legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
            OP_I:              legal = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
            OP_LOAD, OP_STORE: legal = f3 == F3_WORD;
            OP_BRANCH:         legal = f3 != 3'b010 && f3 != 3'b011;
            OP_LUI, OP_JAL:    legal = 1'b1;
            OP_JALR:           legal = f3 == F3_JALR;
            OP_SYSTEM:         legal = ir == INSN_ECALL || ir == INSN_EBREAK;
            default:           legal = 1'b0;
        endcase
    end

    // funct7[5] only selects SUB/SRA; for I-type non-shifts that bit is immediate data
    assign alu_op = (is_r || is_i) ? alu_op_e'({(is_r || f3 == F3_SR) && f7[5], f3}) : ALU_ADD;
    assign alu_a  = is_lui ? '0 : rs1_q;
    assign alu_b  = (is_r || is_branch) ? rs2_q : imm;

    riscv_alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y),
        .eq (eq),
        .lt (lt),
        .ltu(ltu)
    );

    assign taken = f3 == F3_BEQ  ? eq :
                   f3 == F3_BNE  ? !eq :
                   f3 == F3_BLT  ? lt :
                   f3 == F3_BGE  ? !lt :
                   f3 == F3_BLTU ? ltu : !ltu;

    assign target     = is_jalr ? {alu_y[ADDR_W-1:1], 1'b0} : pc_old + imm[ADDR_W-1:0];
    assign redirect   = is_jal || is_jalr || (is_branch && taken);
    assign misaligned = redirect && target[1:0] != 2'b00;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Next-state: wait on memory in FETCH/MEM, HALT and TRAP are terminal until reset
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_n = !legal ? S_TRAP : is_system ? S_HALT : S_EXEC;
            S_EXEC:   state_n = misaligned ? S_TRAP : (is_load || is_store) ? S_MEM : is_branch ? S_FETCH : S_WB;
            S_MEM:    state_n = !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
            S_WB:     state_n = S_FETCH;
            default:  state_n = state;
        endcase
    end

    // Outputs: the request is dropped combinationally while reset is held so an access in flight is abandoned
    always_comb begin
        mem_req   = !reset && (state == S_FETCH || state == S_MEM);
        mem_we    = !reset && state == S_MEM && is_store;
        mem_addr  = {(state == S_MEM ? alu_out[ADDR_W-1:2] : pc[ADDR_W-1:2]), 2'b00};
        mem_wdata = rs2_q;
        halted    = state == S_HALT;
        trap      = state == S_TRAP;
    end

    // Datapath and register file; each state updates only its own registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= RESET_PC;
            pc_old  <= '0;
            ir      <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            trap_pc <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir     <= mem_rdata[31:0];
                    pc_old <= pc;
                    pc     <= pc + ADDR_W'(4);
                end
                S_DECODE: begin
                    rs1_q <= regs[rs1];
                    rs2_q <= regs[rs2];
                    imm   <= XLEN'($signed(imm32(ir)));
                    if (!legal) trap_pc <= pc_old;
                end
                S_EXEC: begin
                    alu_out <= (is_jal || is_jalr) ? XLEN'(pc) : alu_y;
                    if (misaligned)    trap_pc <= pc_old;
                    else if (redirect) pc      <= target;
                end
                S_MEM: if (mem_ready && is_load) mdr <= mem_rdata;
                S_WB: if (rd != '0) regs[rd] <= is_load ? mdr : alu_out;
                default: ;
            endcase
        end
    end

endmodule
